// File: rtl/vga_vtiming.sv
// vga_vtiming -- vertical timing stage for the 800x600@60 SVGA pipeline.
//
// Counts horizontal lines (one per line_done strobe) and produces the
// vertical sync, the vertical-visible flag, the visible row index and a
// frame-start strobe. Every output is registered. The outputs reflect the
// line that starts after the line_done that caused the update.
//
// Ports
//   clk          in   system clock
//   rst_n        in   asynchronous reset, active-low
//   line_done    in   1-cycle strobe: horizontal line finished
//   sync_clr     in   1-cycle strobe: force restart at line 0 (wins over line_done)
//   vsync        out  vertical sync, VSYNC_POL during sync lines
//   v_visible    out  1 during visible lines
//   row          out  visible row index, 0 outside the visible region
//   vcount       out  raw line counter 0..V_TOTAL-1
//   frame_start  out  1-cycle pulse when vcount wraps to 0
//   frame_count  out  frames completed, wraps 255->0
//
// V_SYNC+V_BACK+V_VISIBLE+V_FRONT must not exceed 1024, and every
// region must be at least one line long.
module vga_vtiming #(
    parameter int   V_SYNC    = 4,
    parameter int   V_BACK    = 23,
    parameter int   V_VISIBLE = 600,
    parameter int   V_FRONT   = 1,
    parameter logic VSYNC_POL = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       line_done,
    input  logic       sync_clr,
    output logic       vsync,
    output logic       v_visible,
    output logic [9:0] row,
    output logic [9:0] vcount,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int V_TOTAL = V_SYNC + V_BACK + V_VISIBLE + V_FRONT;

    // Last line number of each region; the FSM leaves a region on the
    // line_done that ends this line.
    localparam logic [9:0] LAST_SYNC = 10'(V_SYNC - 1);
    localparam logic [9:0] LAST_BACK = 10'(V_SYNC + V_BACK - 1);
    localparam logic [9:0] LAST_VIS  = 10'(V_SYNC + V_BACK + V_VISIBLE - 1);
    localparam logic [9:0] LAST_LINE = 10'(V_TOTAL - 1);

    localparam logic [1:0] ST_SYNC  = 2'd0;
    localparam logic [1:0] ST_BACK  = 2'd1;
    localparam logic [1:0] ST_VIS   = 2'd2;
    localparam logic [1:0] ST_FRONT = 2'd3;

    logic [1:0] state;
    logic [1:0] state_n;
    logic [9:0] vcount_n;
    logic [9:0] row_n;
    logic       wrap;

    always_comb begin
        state_n  = state;
        vcount_n = vcount;
        row_n    = row;
        wrap     = 1'b0;
        if (sync_clr) begin
            state_n  = ST_SYNC;
            vcount_n = '0;
            row_n    = '0;
        end else if (line_done) begin
            if (vcount == LAST_LINE) begin
                vcount_n = '0;
            end else begin
                vcount_n = vcount + 10'd1;
            end
            case (state)
                ST_SYNC: begin
                    if (vcount == LAST_SYNC) begin
                        state_n = ST_BACK;
                    end
                end
                ST_BACK: begin
                    if (vcount == LAST_BACK) begin
                        state_n = ST_VIS;
                        row_n   = '0;
                    end
                end
                ST_VIS: begin
                    if (vcount == LAST_VIS) begin
                        state_n = ST_FRONT;
                        row_n   = '0;
                    end else begin
                        row_n = row + 10'd1;
                    end
                end
                ST_FRONT: begin
                    if (vcount == LAST_LINE) begin
                        state_n = ST_SYNC;
                        wrap    = 1'b1;
                    end
                end
                default: begin
                    state_n = ST_SYNC;
                end
            endcase
        end
    end

    // Output flags are decoded from the next state so that they change on
    // the same edge as vcount.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_SYNC;
            vcount      <= '0;
            row         <= '0;
            vsync       <= VSYNC_POL;
            v_visible   <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            state       <= state_n;
            vcount      <= vcount_n;
            row         <= row_n;
            vsync       <= (state_n == ST_SYNC) ? VSYNC_POL : ~VSYNC_POL;
            v_visible   <= (state_n == ST_VIS);
            frame_start <= wrap;
            if (wrap) begin
                frame_count <= frame_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_vtiming.sv
// Scoreboard bench for vga_vtiming. The stimulus process drives inputs on
// the falling edge and pushes the expected post-edge outputs; the monitor
// pops and compares after each rising edge (and right after an async reset).
// Instance dut runs the 800x600 timing; dut2 uses a 5-line frame so the
// 8-bit frame counter wrap is reached quickly.
module tb_vga_vtiming;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       line_done = 1'b0;
    logic       sync_clr = 1'b0;
    logic       ld2 = 1'b0;
    logic       vsync, v_visible, frame_start;
    logic [9:0] row, vcount;
    logic [7:0] frame_count;
    logic       vsync2, v_visible2, frame_start2;
    logic [9:0] row2, vcount2;
    logic [7:0] frame_count2;

    always #5 clk = ~clk;

    vga_vtiming dut (
        .clk(clk), .rst_n(rst_n), .line_done(line_done), .sync_clr(sync_clr),
        .vsync(vsync), .v_visible(v_visible), .row(row), .vcount(vcount),
        .frame_start(frame_start), .frame_count(frame_count)
    );

    vga_vtiming #(.V_SYNC(1), .V_BACK(1), .V_VISIBLE(2), .V_FRONT(1), .VSYNC_POL(1'b1)) dut2 (
        .clk(clk), .rst_n(rst_n), .line_done(ld2), .sync_clr(1'b0),
        .vsync(vsync2), .v_visible(v_visible2), .row(row2), .vcount(vcount2),
        .frame_start(frame_start2), .frame_count(frame_count2)
    );

    typedef struct {
        string nm;
        int    id;
        bit    vs;
        bit    vis;
        int    row;
        int    vc;
        bit    fs;
        int    fc;
    } exp_t;

    exp_t  q[$];
    int    checks = 0;
    int    passed = 0;
    string phase = "reset";
    int    m_vc[2] = '{0, 0};
    int    m_fc[2] = '{0, 0};

    function automatic int tot(int id);    return (id == 0) ? 628 : 5; endfunction
    function automatic int sync_n(int id); return (id == 0) ? 4 : 1;   endfunction
    function automatic int vis_lo(int id); return (id == 0) ? 27 : 2;  endfunction
    function automatic int vis_hi(int id); return (id == 0) ? 626 : 3; endfunction

    // Line-number based reference: outputs follow from vcount alone.
    task automatic model(int id, bit ld, bit clr, bit rst);
        exp_t e;
        bit   fs;
        fs = 1'b0;
        if (rst) begin
            m_vc[id] = 0;
            m_fc[id] = 0;
        end else if (clr) begin
            m_vc[id] = 0;
        end else if (ld) begin
            if (m_vc[id] == tot(id) - 1) begin
                m_vc[id] = 0;
                m_fc[id] = (m_fc[id] + 1) % 256;
                fs = 1'b1;
            end else begin
                m_vc[id] = m_vc[id] + 1;
            end
        end
        e.nm  = phase;
        e.id  = id;
        e.vs  = (m_vc[id] < sync_n(id));
        e.vis = (m_vc[id] >= vis_lo(id)) && (m_vc[id] <= vis_hi(id));
        e.row = e.vis ? (m_vc[id] - vis_lo(id)) : 0;
        e.vc  = m_vc[id];
        e.fs  = fs;
        e.fc  = m_fc[id];
        q.push_back(e);
    endtask

    task automatic step(bit ld, bit clr, bit l2);
        @(negedge clk);
        line_done = ld;
        sync_clr  = clr;
        ld2       = l2;
        model(0, ld, clr, !rst_n);
        model(1, l2, 1'b0, !rst_n);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n     = 1'b1;
        line_done = 1'b0;
        sync_clr  = 1'b0;
        ld2       = 1'b0;
        model(0, 1'b0, 1'b0, 1'b0);
        model(1, 1'b0, 1'b0, 1'b0);
    endtask

    // Reset asserted between clock edges; the monitor checks it before the
    // next rising edge arrives.
    task automatic async_reset();
        @(negedge clk);
        line_done = 1'b0;
        sync_clr  = 1'b0;
        ld2       = 1'b0;
        #2;
        rst_n = 1'b0;
        model(0, 1'b0, 1'b0, 1'b1);
        model(1, 1'b0, 1'b0, 1'b1);
    endtask

    // Monitor
    initial begin
        exp_t e;
        bit   avs, avis, afs;
        int   arow, avc, afc;
        forever begin
            @(posedge clk or negedge rst_n);
            #1;
            while (q.size() > 0) begin
                e = q.pop_front();
                if (e.id == 0) begin
                    avs = vsync;  avis = v_visible;  afs = frame_start;
                    arow = int'(row);  avc = int'(vcount);  afc = int'(frame_count);
                end else begin
                    avs = vsync2; avis = v_visible2; afs = frame_start2;
                    arow = int'(row2); avc = int'(vcount2); afc = int'(frame_count2);
                end
                checks++;
                if (avs === e.vs && avis === e.vis && afs === e.fs &&
                    arow == e.row && avc == e.vc && afc == e.fc) begin
                    passed++;
                end else begin
                    $display("FAIL %s id=%0d got vs=%0b vis=%0b row=%0d vc=%0d fs=%0b fc=%0d expected vs=%0b vis=%0b row=%0d vc=%0d fs=%0b fc=%0d",
                             e.nm, e.id, avs, avis, arow, avc, afs, afc,
                             e.vs, e.vis, e.row, e.vc, e.fs, e.fc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

    // Stimulus
    initial begin
        phase = "reset";
        repeat (3) step(1'b0, 1'b0, 1'b0);
        release_reset();
        step(1'b0, 1'b0, 1'b0);

        phase = "sync_to_back";
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0);
        end

        phase = "frame1";
        for (int i = 0; i < 624; i++) step(1'b1, 1'b0, 1'b0);
        phase = "frame_start_clear";
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        phase = "to_300";
        for (int i = 0; i < 300; i++) step(1'b1, 1'b0, 1'b0);
        phase = "sync_clr";
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);

        phase = "to_500";
        for (int i = 0; i < 499; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        phase = "async_reset";
        async_reset();
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        release_reset();
        phase = "restart";
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        phase = "frame_count_wrap";
        for (int i = 0; i < 256 * 5; i++) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        @(posedge clk);
        #3;
        if (q.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d expected entries left, required 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
